// File: rtl/prog_fetch.sv
// Loadable 16x8 instruction-fetch stage: byte-stream program load, then one fetch per clock.
// Latency: load_ready 1 cycle after load_start; first instruction valid 1 cycle after run is sampled.
// Backpressure: load_ready is high only in LOAD; gaps in load_valid stall the load without effect.
//
// Ports:
//   clk, rst (async active-low)
//   load_start / load_valid / load_data / load_ready / load_done : program load stream
//   run / stop / restart                                           : execution control
//   pc / opcode / imm / instr_valid / loaded                       : fetch outputs and status
module prog_fetch #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [DATA_W-1:0]   load_data,
  output logic                load_ready,
  output logic                load_done,
  input  logic                run,
  input  logic                stop,
  input  logic                restart,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W/2-1:0] opcode,
  output logic [DATA_W/2-1:0] imm,
  output logic                instr_valid,
  output logic                loaded
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W/2-1:0] r_opcode;
  logic [DATA_W/2-1:0] r_imm;
  logic                r_instr_valid;
  logic                r_load_done;
  logic                r_loaded;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_wr_fire;

  // Ready is a pure function of state so the loader sees it without an extra cycle.
  assign load_ready  = (r_state == LOAD);
  assign w_wr_fire   = load_ready & load_valid;

  assign pc          = r_pc;
  assign opcode      = r_opcode;
  assign imm         = r_imm;
  assign instr_valid = r_instr_valid;
  assign load_done   = r_load_done;
  assign loaded      = r_loaded;

  // Program memory deliberately has no reset: contents survive reset and are
  // only replaced by a new load. Writes are gated by LOAD state, which is reset.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wptr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_wptr        <= '0;
      r_pc          <= '0;
      r_opcode      <= '0;
      r_imm         <= '0;
      r_instr_valid <= 1'b0;
      r_load_done   <= 1'b0;
      r_loaded      <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_instr_valid <= 1'b0;
          r_opcode      <= '0;
          r_imm         <= '0;
          if (load_start) begin
            r_state  <= LOAD;
            r_wptr   <= '0;
            r_loaded <= 1'b0;
          end else if (run && r_loaded) begin
            r_state <= RUN;
            r_pc    <= '0;
          end
        end

        LOAD: begin
          if (w_wr_fire) begin
            r_wptr <= r_wptr + ONE;
            // The 16th byte completes the program; the pointer wraps on its own.
            if (r_wptr == LAST) begin
              r_state     <= IDLE;
              r_loaded    <= 1'b1;
              r_load_done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (stop) begin
            // pc is held so the stop point is visible after leaving RUN.
            r_state       <= IDLE;
            r_instr_valid <= 1'b0;
            r_opcode      <= '0;
            r_imm         <= '0;
          end else if (restart) begin
            // One bubble cycle; mem[0] is fetched on the following edge.
            r_pc          <= '0;
            r_instr_valid <= 1'b0;
            r_opcode      <= '0;
            r_imm         <= '0;
          end else begin
            {r_opcode, r_imm} <= r_mem[r_pc];
            r_instr_valid     <= 1'b1;
            r_pc              <= r_pc + ONE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_fetch.sv
// Testbench for prog_fetch: randomized and directed stimulus against a behavioural model.
// Latency: model advances on each rising edge; outputs are checked 1 time unit later.
// Backpressure: the model accepts load bytes only while it is in its loading phase.
module tb_prog_fetch;

  logic       clk;
  logic       rst;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic       run;
  logic       stop;
  logic       restart;
  logic [3:0] pc;
  logic [3:0] opcode;
  logic [3:0] imm;
  logic       instr_valid;
  logic       loaded;

  int n_cmp = 0;
  int n_err = 0;

  prog_fetch #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .run        (run),
    .stop       (stop),
    .restart    (restart),
    .pc         (pc),
    .opcode     (opcode),
    .imm        (imm),
    .instr_valid(instr_valid),
    .loaded     (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a program image, a count of received bytes,
  // a mode flag pair and the instruction currently presented.
  logic [7:0] m_mem [16];
  int         m_wcnt;
  int         m_pc;
  bit         m_loading;
  bit         m_running;
  bit         m_loaded;
  bit         m_done;
  bit         m_vld;
  logic [7:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcnt    = 0;
    m_pc      = 0;
    m_loading = 0;
    m_running = 0;
    m_loaded  = 0;
    m_done    = 0;
    m_vld     = 0;
    m_instr   = 8'h00;
  endtask

  task automatic model_step();
    m_done = 0;
    if (m_loading) begin
      if (load_valid) begin
        m_mem[m_wcnt] = load_data;
        m_wcnt++;
        if (m_wcnt == 16) begin
          m_wcnt    = 0;
          m_loading = 0;
          m_loaded  = 1;
          m_done    = 1;
        end
      end
    end else if (m_running) begin
      if (stop) begin
        m_running = 0;
        m_vld     = 0;
        m_instr   = 8'h00;
      end else if (restart) begin
        m_pc    = 0;
        m_vld   = 0;
        m_instr = 8'h00;
      end else begin
        m_instr = m_mem[m_pc];
        m_vld   = 1;
        m_pc    = (m_pc + 1) % 16;
      end
    end else begin
      if (load_start) begin
        m_loading = 1;
        m_wcnt    = 0;
        m_loaded  = 0;
      end else if (run && m_loaded) begin
        m_running = 1;
        m_pc      = 0;
        m_vld     = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},          32'(pc),          32'(m_pc));
    chk({tag, ".opcode"},      32'(opcode),      32'(m_instr[7:4]));
    chk({tag, ".imm"},         32'(imm),         32'(m_instr[3:0]));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_vld));
    chk({tag, ".loaded"},      32'(loaded),      32'(m_loaded));
    chk({tag, ".load_ready"},  32'(load_ready),  32'(m_loading));
    chk({tag, ".load_done"},   32'(load_done),   32'(m_done));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    load_start = 0;
    load_valid = 0;
    load_data  = 8'h00;
    run        = 0;
    stop       = 0;
    restart    = 0;
  endtask

  // Reset asserted between edges; outputs must change without a clock.
  task automatic reset_midcycle(input string tag);
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_b;
    int         guard;

    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    rst = 1'b1;
    tick("idle");

    // run before any load is ignored
    run = 1;
    tick("run_noload");
    run = 0;
    tick("run_noload2");
    chk("run_noload_vld", 32'(instr_valid), 32'd0);

    // load 0x10..0x1F with a gap every other cycle
    load_start = 1;
    tick("ld_start");
    load_start = 0;
    for (int i = 0; i < 40 && m_loading; i++) begin
      load_valid = (i % 2 == 1);
      load_data  = load_valid ? 8'(8'h10 + m_wcnt) : 8'($urandom);
      tick("ld_gap");
    end
    idle_inputs();
    chk("ld_gap_done", 32'(load_done), 32'd1);
    chk("ld_gap_ready", 32'(load_ready), 32'd0);
    tick("ld_after");
    chk("ld_done_once", 32'(load_done), 32'd0);
    chk("ld_loaded", 32'(loaded), 32'd1);

    // run and wrap through 17 fetches
    run = 1;
    tick("run_go");
    run = 0;
    chk("run_bubble", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 17; k++) begin
      tick("fetch");
      exp_b = 8'h10 | 8'(k % 16);
      chk("fetch_seq", 32'({opcode, imm}), 32'(exp_b));
      chk("fetch_vld", 32'(instr_valid), 32'd1);
    end

    // restart while pc = 5
    guard = 0;
    while (m_pc != 5 && guard < 20) begin
      tick("to_pc5");
      guard++;
    end
    chk("reach_pc5", 32'(pc), 32'd5);
    restart = 1;
    tick("restart");
    restart = 0;
    chk("restart_vld", 32'(instr_valid), 32'd0);
    chk("restart_op", 32'(opcode), 32'd0);
    tick("restart_fetch");
    chk("restart_mem0", 32'({opcode, imm}), 32'h10);

    // load_start during RUN is ignored
    load_start = 1;
    tick("ls_in_run");
    load_start = 0;
    chk("ls_in_run_rdy", 32'(load_ready), 32'd0);
    tick("ls_in_run2");

    // stop wins over restart
    stop    = 1;
    restart = 1;
    tick("stop_restart");
    idle_inputs();
    tick("stopped");
    chk("stopped_vld", 32'(instr_valid), 32'd0);

    // run again, then reset mid-run
    run = 1;
    tick("rerun");
    run = 0;
    repeat (6) tick("rerun_fetch");
    reset_midcycle("rst_midrun");
    tick("rst_release");

    // reset mid-load after 7 bytes
    load_start = 1;
    tick("ld2_start");
    load_start = 0;
    for (int i = 0; i < 7; i++) begin
      load_valid = 1;
      load_data  = 8'($urandom);
      tick("ld2_byte");
    end
    reset_midcycle("rst_midload");
    run = 1;
    tick("run_after_rst");
    run = 0;
    tick("run_after_rst2");
    chk("run_after_rst_vld", 32'(instr_valid), 32'd0);

    // full back-to-back reload: load_done 17 cycles after load_start
    load_start = 1;
    tick("ld3_start");
    load_start = 0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1;
      load_data  = 8'($urandom);
      tick("ld3_byte");
    end
    idle_inputs();
    chk("ld3_done_17", 32'(load_done), 32'd1);
    run = 1;
    tick("run3");
    run = 0;
    repeat (20) tick("run3_fetch");

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      load_start = ($urandom_range(0, 29) == 0);
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = 8'($urandom);
      run        = ($urandom_range(0, 5) == 0);
      stop       = ($urandom_range(0, 39) == 0);
      restart    = ($urandom_range(0, 19) == 0);
      tick("rand");
    end
    idle_inputs();
    tick("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_fetch.md
# prog_fetch

Loadable instruction-fetch stage that sits directly upstream of `instruction_decoder`, `alu` and the accumulator mux. It replaces the fixed `program_counter` + `rom16x8` pair:
- a 16x8 program memory is filled byte-by-byte over a valid/ready stream;
- in run mode it fetches one instruction per clock, presenting the upper nibble as opcode and the lower nibble as immediate;
- the decoder's `reset` output restarts the program from address 0.

## Interface
- `ADDR_W`, 4, program address width (memory depth 2^ADDR_W = 16)
- `DATA_W`, 8, instruction width; opcode = `[DATA_W-1:DATA_W/2]`, imm = `[DATA_W/2-1:0]`

Ports:
- `clk` in 1 — single clock, all state changes on rising edge
- `rst` in 1 — asynchronous, active-low reset
- `load_start` in 1 — request to (re)load the program; honoured only in IDLE
- `load_valid` in 1 — byte on `load_data` is valid
- `load_data` in DATA_W — program byte
- `load_ready` out 1 — block accepts a byte this cycle
- `load_done` out 1 — one-cycle pulse after the last byte is written
- `run` in 1 — start execution; honoured only in IDLE with a complete program loaded
- `stop` in 1 — leave RUN and return to IDLE
- `restart` in 1 — from decoder `reset`; PC returns to 0 while running
- `pc` out ADDR_W — address of the next fetch
- `opcode` out DATA_W/2 — to decoder `instr`
- `imm` out DATA_W/2 — to mux immediate input
- `instr_valid` out 1 — `opcode`/`imm` hold a fetched instruction
- `loaded` out 1 — memory holds a complete 16-byte program

## Operation
- FSM states: IDLE (0), LOAD (1), RUN (2).
- IDLE → LOAD on `load_start`:
  - write pointer ← 0
  - `loaded` ← 0
- LOAD:
  - `load_ready` = 1 (combinational from state).
  - On `load_valid && load_ready`: write `mem[wptr]`, then `wptr` ← `wptr`+1.
  - Write at `wptr` = 15 completes the load: `wptr` wraps to 0, state → IDLE, `loaded` ← 1, `load_done` = 1 for exactly one cycle.
  - Gaps in `load_valid` stall without effect.
  - `load_start`, `run`, `stop` and `restart` are ignored in LOAD.
- IDLE → RUN on `run && loaded`:
  - `pc` ← 0
  - `instr_valid` ← 0
- `run` with `loaded` = 0 is ignored; state stays IDLE.
- RUN, each edge with no `stop`/`restart`:
  - `{opcode, imm}` ← `mem[pc]`
  - `instr_valid` ← 1
  - `pc` ← `pc`+1, mod 16; 15 wraps to 0 and the program loops
- RUN with `restart` = 1 (and `stop` = 0):
  - `pc` ← 0
  - `opcode`/`imm` ← 0
  - `instr_valid` ← 0 (one bubble)
  - The fetch of `mem[0]` occurs on the following edge.
- RUN with `stop` = 1: state → IDLE, `instr_valid` ← 0, `opcode`/`imm` ← 0; `pc` holds its value. `stop` has priority over `restart`.
- In IDLE: `instr_valid` = 0 and `opcode`/`imm` = 0, so downstream sees NOP 0000.
- Memory is not cleared by reset or `load_start`. Contents are only overwritten by LOAD writes.

## Timing
- Reset (`rst` = 0, asynchronous), immediate values:
  - state IDLE
  - `pc` = 0, `wptr` = 0
  - `opcode` = 0, `imm` = 0
  - `instr_valid` = 0, `load_ready` = 0, `load_done` = 0, `loaded` = 0
- Release of `rst` is taken synchronously at the next rising edge.
- Reset mid-load or mid-run aborts immediately. `loaded` = 0, so a full reload is required before `run`.
- Load latency: `load_ready` high the cycle after `load_start` is sampled. `load_done` is high the cycle after the 16th handshake, and `load_ready` is 0 in that same cycle.
- Minimum load: 17 cycles from `load_start` to `load_done` (1 + 16 back-to-back bytes).
- Fetch latency: `run` sampled at edge N. `mem[0]` is valid on outputs after edge N+1, and `mem[k]` after edge N+1+k.
- Output is one instruction per cycle: registered outputs, no combinational path from inputs.
- `pc` after edge N+1+k = (k+1) mod 16.

## Test plan
- Reset: assert `rst` = 0 mid-cycle. All outputs go to their reset values immediately (`pc` = 0, `instr_valid` = 0, `opcode` = 0, `loaded` = 0) without waiting for a clock edge.
- Load with gaps: `load_start`, then bytes 0x10..0x1F with `load_valid` low every other cycle. Exactly 16 writes occur, `load_done` pulses once, `load_ready` drops, `loaded` = 1, state IDLE.
- Run and wrap: after the load above, pulse `run`. `opcode`/`imm` sequence is 1/0, 1/1, … 1/F, then 1/0 again at cycle 17; `instr_valid` is 1 from the first fetch.
- Restart mid-run: assert `restart` while `pc` = 5. Next cycle `instr_valid` = 0 and `opcode` = 0, then the fetch of `mem[0]` (0x10). Assert `stop` together with `restart`: state → IDLE.
- Guards: `run` before any load leaves the block in IDLE with `instr_valid` = 0. `load_start` during RUN is ignored.
- Reset mid-load: apply reset after 7 bytes. `loaded` = 0 and `run` is ignored. A full reload then succeeds.
